// File: rtl/nibble_adder_tester.sv
// Self-test initiator for the 4-bit nibble adder tile: sweeps operand pairs, checks results after LATENCY edges.
// Optional: define CARRY_CHECK_EN to check the full 5-bit sum and require sum_in[7:5]==0.
module nibble_adder_tester #(
    parameter int NUM_VECTORS = 256,
    parameter int LATENCY     = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] operand_out,
    input  logic [7:0] sum_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic       fail_valid,
    output logic [7:0] fail_vec
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic       valid;
        logic [7:0] vec;
        logic [4:0] expected;
    } entry_t;

    state_t     state_reg, state_next;
    logic [8:0] index_reg, index_next;
    logic [2:0] drain_reg, drain_next;
    logic [7:0] operand_reg, operand_next;
    logic       launch;
    logic [7:0] launch_vec;
    logic       clear_run;

    entry_t     pipe_reg [LATENCY+1];
    entry_t     push_entry;
    entry_t     head;
    logic       mismatch;

    logic [7:0] err_reg;
    logic       fail_valid_reg;
    logic [7:0] fail_vec_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            index_reg   <= '0;
            drain_reg   <= '0;
            operand_reg <= '0;
        end else begin
            state_reg   <= state_next;
            index_reg   <= index_next;
            drain_reg   <= drain_next;
            operand_reg <= operand_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        index_next   = index_reg;
        drain_next   = drain_reg;
        operand_next = operand_reg;
        launch       = 1'b0;
        launch_vec   = '0;
        clear_run    = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next   = RUN;
                    operand_next = '0;
                    index_next   = 9'd1;
                    clear_run    = 1'b1;
                    launch       = 1'b1;
                end
            end
            RUN: begin
                // index has run past the last vector: stop launching and let the pipe empty
                if (index_reg == 9'(NUM_VECTORS)) begin
                    state_next   = DRAIN;
                    operand_next = '0;
                    drain_next   = '0;
                end else begin
                    launch       = 1'b1;
                    launch_vec   = index_reg[7:0];
                    operand_next = index_reg[7:0];
                    index_next   = index_reg + 9'd1;
                end
            end
            DRAIN: begin
                if (drain_reg == 3'(LATENCY)) begin
                    state_next = DONE;
                end else begin
                    drain_next = drain_reg + 3'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        push_entry.valid    = launch;
        push_entry.vec      = launch_vec;
        push_entry.expected = {1'b0, launch_vec[7:4]} + {1'b0, launch_vec[3:0]};
    end

    // Expected-result pipeline: entry launched on edge k reaches the head for the compare on edge k+LATENCY+1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= LATENCY; i++) begin
                pipe_reg[i] <= '0;
            end
        end else begin
            pipe_reg[0] <= push_entry;
            for (int i = 1; i <= LATENCY; i++) begin
                pipe_reg[i] <= pipe_reg[i-1];
            end
        end
    end

    assign head = pipe_reg[LATENCY];

`ifdef CARRY_CHECK_EN
    assign mismatch = head.valid && (sum_in != {3'b000, head.expected});
`else
    logic unused_upper;
    assign unused_upper = ^{sum_in[7:4], head.expected[4]};
    assign mismatch     = head.valid && (sum_in[3:0] != head.expected[3:0]);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_reg        <= '0;
            fail_valid_reg <= 1'b0;
            fail_vec_reg   <= '0;
        end else if (clear_run) begin
            err_reg        <= '0;
            fail_valid_reg <= 1'b0;
            fail_vec_reg   <= '0;
        end else if (mismatch) begin
            if (err_reg != 8'hFF) begin
                err_reg <= err_reg + 8'd1;
            end
            if (!fail_valid_reg) begin
                fail_valid_reg <= 1'b1;
                fail_vec_reg   <= head.vec;
            end
        end
    end

    assign operand_out = operand_reg;
    assign busy        = (state_reg == RUN) || (state_reg == DRAIN);
    assign done        = (state_reg == DONE);
    assign pass        = done && (err_reg == 8'd0);
    assign err_count   = err_reg;
    assign fail_valid  = fail_valid_reg;
    assign fail_vec    = fail_vec_reg;

endmodule

// File: tb/tb_nibble_adder_tester.sv
// Bench for nibble_adder_tester: configurable adder model, run-level reference model checked every cycle.
module tb_nibble_adder_tester;

    localparam int N = 256;
    localparam int L = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] operand_out;
    logic [7:0] sum_in;
    logic       busy, done, pass, fail_valid;
    logic [7:0] err_count, fail_vec;

    always #5 clk = ~clk;

    nibble_adder_tester #(.NUM_VECTORS(N), .LATENCY(L)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .operand_out(operand_out),
        .sum_in     (sum_in),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_valid (fail_valid),
        .fail_vec   (fail_vec)
    );

    // Adder under test: mode 0 ideal with per-operand xor faults, 1 result bit 0 stuck at 0, 2 four-bit sum only
    int         mode = 0;
    logic [7:0] mask [256];
    logic [7:0] apipe [L];

    function automatic logic [7:0] adder_fn(input logic [7:0] op);
        logic [4:0] s;
        s = {1'b0, op[7:4]} + {1'b0, op[3:0]};
        case (mode)
            1:       return {3'b000, s} & 8'hFE;
            2:       return {4'b0000, s[3:0]};
            default: return {3'b000, s} ^ mask[op];
        endcase
    endfunction

    always @(posedge clk) begin
        apipe[0] <= adder_fn(operand_out);
        for (int i = 1; i < L; i++) apipe[i] <= apipe[i-1];
    end
    assign sum_in = apipe[L-1];

    function automatic bit is_bad(input int k);
        logic [7:0] op, act;
        int         ideal;
        op    = 8'(k);
        act   = adder_fn(op);
        ideal = int'(op[7:4]) + int'(op[3:0]);
`ifdef CARRY_CHECK_EN
        return int'(act) != ideal;
`else
        return int'(act[3:0]) != (ideal % 16);
`endif
    endfunction

    // Run-level reference: m_t is the number of edges since the accepted start edge
    bit m_active = 0;
    bit m_done   = 0;
    int m_t      = 0;
    bit bad_run [256];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_active <= 0;
            m_done   <= 0;
            m_t      <= 0;
        end else if (!m_active && start) begin
            m_active <= 1;
            m_done   <= 0;
            m_t      <= 0;
            for (int k = 0; k < 256; k++) bad_run[k] <= is_bad(k);
        end else if (m_active) begin
            m_t <= m_t + 1;
            if (m_t + 1 == N + L + 1) begin
                m_active <= 0;
                m_done   <= 1;
            end
        end
    end

    int checks = 0;
    int passes = 0;
    bit chk_en = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        int cnt, first, lim, exp_op;
        if (chk_en) begin
            cnt   = 0;
            first = 0;
            lim   = 0;
            if (m_done) lim = N;
            else if (m_active) lim = (m_t - L > N) ? N : m_t - L;
            for (int k = 0; k < lim; k++) begin
                if (bad_run[k]) begin
                    if (cnt == 0) first = k;
                    cnt++;
                end
            end
            exp_op = (m_active && m_t < N) ? m_t : 0;
            check("busy",        int'(busy),        int'(m_active));
            check("done",        int'(done),        int'(m_done));
            check("err_count",   int'(err_count),   (cnt > 255) ? 255 : cnt);
            check("fail_valid",  int'(fail_valid),  int'(cnt > 0));
            check("fail_vec",    int'(fail_vec),    first);
            check("pass",        int'(pass),        int'(m_done && cnt == 0));
            check("operand_out", int'(operand_out), exp_op);
        end
    end

    task automatic do_run(input string tag, input int inject_at, output int edge_done);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        edge_done = 0;
        @(negedge clk);
        start = 1'b0;
        while (!done && edge_done < 600) begin
            start = (edge_done + 1 == inject_at);
            @(posedge clk);
            edge_done++;
            @(negedge clk);
            start = 1'b0;
        end
        check({tag, "_finished"}, int'(done), 1);
        $display("run %-8s done_edge=%0d err_count=%0d fail_valid=%0b fail_vec=%02h pass=%0b",
                 tag, edge_done, err_count, fail_valid, fail_vec, pass);
    endtask

    initial begin
        int e;
        for (int k = 0; k < 256; k++) mask[k] = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_operand", int'(operand_out), 0);
        check("reset_busy",    int'(busy),        0);
        #2 reset = 1'b0;
        chk_en = 1;
        @(negedge clk);

        // ideal adder, stray start at edge 50
        mode = 0;
        do_run("ideal", 50, e);
        check("ideal_done_edge", e, N + L + 1);
        check("ideal_done_lit",  e, 258);
        check("ideal_err",       int'(err_count), 0);
        check("ideal_pass",      int'(pass), 1);
        check("ideal_fvalid",    int'(fail_valid), 0);

        // stuck-at-0 on bit 0, started from DONE
        mode = 1;
        do_run("stuck0", -1, e);
        check("stuck_err",   int'(err_count), 128);
        check("stuck_pass",  int'(pass), 0);
        check("stuck_fvec",  int'(fail_vec), 8'h01);
        check("stuck_edge",  e, 258);

        // adder drives only four result bits
        mode = 2;
        do_run("carry", -1, e);
`ifdef CARRY_CHECK_EN
        check("carry_err",  int'(err_count), 120);
        check("carry_fvec", int'(fail_vec), 8'h1F);
        check("carry_pass", int'(pass), 0);
`else
        check("carry_err",  int'(err_count), 0);
        check("carry_pass", int'(pass), 1);
`endif

        // every vector faulty: count saturates at 255
        mode = 0;
        for (int k = 0; k < 256; k++) mask[k] = 8'h01 | 8'($urandom_range(0, 255));
        do_run("saturate", -1, e);
        check("sat_err",  int'(err_count), 255);
        check("sat_fvec", int'(fail_vec), 0);
        check("sat_pass", int'(pass), 0);

        // sparse random faults, some only in the upper result bits
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 256; k++)
                mask[k] = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            do_run("random", int'($urandom_range(2, 250)), e);
        end

        // reset at edge 100 of a failing run
        mode = 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        check("pre_reset_busy", int'(busy), 1);
        #2 reset = 1'b1;
        @(negedge clk);
        check("rst_err",    int'(err_count), 0);
        check("rst_busy",   int'(busy), 0);
        check("rst_fvalid", int'(fail_valid), 0);
        check("rst_fvec",   int'(fail_vec), 0);
        check("rst_done",   int'(done), 0);
        #2 reset = 1'b0;
        mode = 0;
        for (int k = 0; k < 256; k++) mask[k] = 8'h00;
        do_run("after_rst", -1, e);
        check("after_rst_pass", int'(pass), 1);
        check("after_rst_err",  int'(err_count), 0);
        check("after_rst_edge", e, 258);

        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
